sdram_frame_reader: RTL and testbench

Downstream consumer of the SDRAM frame store filled by the SD-card-to-SDRAM writer. On a start pulse it streams one selected frame (64 frames × 1024 lines × 512 16-bit words) out of SDRAM via an Avalon-MM-style pipelined read port. Read data is buffered in an internal FIFO and presented to the SLM display pipeline through a valid/ready stream. Outstanding reads are credit-limited so the FIFO can never overflow.

---
 rtl/sdram_frame_pkg.sv | 18 +
 rtl/sync_fifo_fwft.sv | 64 ++++++
 rtl/sdram_frame_reader.sv | 152 +++++++++++++++
 tb/tb_sdram_frame_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_frame_pkg.sv
// Shared definitions for the SDRAM frame store: FSM encodings and address/data field widths.
// Imported by both the SD-card writer and the frame reader.
package sdram_frame_pkg;

    localparam int FRAME_W = 6;
    localparam int LINE_W  = 10;
    localparam int WORD_W  = 9;
    localparam int ADDR_W  = 25;
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE_AND_WAIT
    } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; the head word is presented while empty_o is low.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_fwft #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_eff;
    logic             push_eff;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CW'(DEPTH));
    assign count_o  = count_q;
    assign pop_eff  = pop_i && !empty_o;
    assign push_eff = push_i && (!full_o || pop_eff);
    assign rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: the storage array has no reset; only pointers and count need one, and
    // leaving the array out keeps it mappable onto RAM.
    always_ff @(posedge clk_i) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_eff)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_eff, pop_eff})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The upstream credit scheme must never push into a full FIFO without a pop.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push_i && full_o && !pop_i));

endmodule

// File: rtl/sdram_frame_reader.sv
// Streams one frame from SDRAM through a credit-limited read port into a FWFT FIFO.
// Define SDRAM_READER_LOOP_EN to re-read the same frame continuously while iSTART stays high.
module sdram_frame_reader
    import sdram_frame_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int LINES_PER_FRAME = 1024,
    parameter int WORDS_PER_LINE  = 512
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iSTART,
    input  logic [FRAME_W-1:0] iFRAME_ID,
    input  logic              iWAIT_REQUEST,
    input  logic [DATA_W-1:0] iRD_DATA,
    input  logic              iRD_DATAVALID,
    output logic              oRD_EN,
    output logic [ADDR_W-1:0] oRD_ADDR,
    output logic [DATA_W-1:0] oPIX_DATA,
    output logic              oPIX_VALID,
    input  logic              iPIX_READY,
    output logic              oBUSY,
    output logic              oDONE
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_FRAME - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [OUT_W-1:0]   outst_q, outst_d;
    logic               start_q;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               start_rise;
    logic               rd_valid;
    logic               credit_ok;
    logic               accept;
    logic               last_addr;

    assign start_rise = iSTART && !start_q;
    assign oBUSY      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign oDONE      = (state_q == ST_IDLE) || (state_q == ST_DONE_AND_WAIT);
    // Returned data outside a transfer is stale and must not touch the FIFO or the credit count.
    assign rd_valid   = iRD_DATAVALID && oBUSY;
    assign credit_ok  = (outst_q < OUT_W'(MAX_OUTSTANDING)) && !fifo_full &&
                        ((SUM_W'(fifo_count) + SUM_W'(outst_q)) < SUM_W'(FIFO_DEPTH));
    assign oRD_EN     = (state_q == ST_ISSUE) && credit_ok;
    assign accept     = oRD_EN && !iWAIT_REQUEST;
    assign last_addr  = (line_q == LAST_LINE) && (word_q == LAST_WORD);
    assign oRD_ADDR   = {frame_q, line_q, word_q};
    assign oPIX_VALID = !fifo_empty;

    always_comb begin
        case ({accept, rd_valid})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase
    end

    // NOTE: every next-state variable takes its hold value first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        line_d  = line_q;
        word_d  = word_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_ISSUE;
                    frame_d = iFRAME_ID;
                    line_d  = '0;
                    word_d  = '0;
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    if (last_addr) begin
                        line_d = '0;
                        word_d = '0;
`ifdef SDRAM_READER_LOOP_EN
                        state_d = iSTART ? ST_ISSUE : ST_DRAIN;
`else
                        state_d = ST_DRAIN;
`endif
                    end else if (word_q == LAST_WORD) begin
                        word_d = '0;
                        line_d = line_q + LINE_W'(1);
                    end else begin
                        word_d = word_q + WORD_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if ((outst_q == '0) && fifo_empty) begin
`ifdef SDRAM_READER_LOOP_EN
                    state_d = iSTART ? ST_ISSUE : ST_DONE_AND_WAIT;
`else
                    state_d = ST_DONE_AND_WAIT;
`endif
                end
            end
            ST_DONE_AND_WAIT: begin
                if (!iSTART) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            line_q  <= '0;
            word_q  <= '0;
            outst_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            line_q  <= line_d;
            word_q  <= word_d;
            outst_q <= outst_d;
            start_q <= iSTART;
        end
    end

    sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk_i   (iCLK),
        .rst_n_i (iRST_N),
        .push_i  (rd_valid),
        .wdata_i (iRD_DATA),
        .pop_i   (iPIX_READY),
        .rdata_o (oPIX_DATA),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed bench for sdram_frame_reader with a 2-cycle-latency SDRAM model and a small frame geometry.
// The continuous-refresh step runs only when SDRAM_READER_LOOP_EN is defined.
module tb_sdram_frame_reader;

    localparam int LPF = 2;
    localparam int WPL = 16;
    localparam int NWORDS = LPF * WPL;

    logic        iCLK;
    logic        iRST_N;
    logic        iSTART;
    logic [5:0]  iFRAME_ID;
    logic        iWAIT_REQUEST;
    logic [15:0] iRD_DATA;
    logic        iRD_DATAVALID;
    logic        iPIX_READY;
    logic        oRD_EN;
    logic [24:0] oRD_ADDR;
    logic [15:0] oPIX_DATA;
    logic        oPIX_VALID;
    logic        oBUSY;
    logic        oDONE;

    int n_checks = 0;
    int n_fail   = 0;

    logic [24:0] acc_q[$];
    logic [15:0] out_q[$];
    logic        p0_v, p1_v;
    logic [15:0] p0_d, p1_d;
    logic        stray_req;

    sdram_frame_reader #(
        .FIFO_DEPTH      (16),
        .MAX_OUTSTANDING (8),
        .LINES_PER_FRAME (LPF),
        .WORDS_PER_LINE  (WPL)
    ) dut (
        .iCLK          (iCLK),
        .iRST_N        (iRST_N),
        .iSTART        (iSTART),
        .iFRAME_ID     (iFRAME_ID),
        .iWAIT_REQUEST (iWAIT_REQUEST),
        .iRD_DATA      (iRD_DATA),
        .iRD_DATAVALID (iRD_DATAVALID),
        .oRD_EN        (oRD_EN),
        .oRD_ADDR      (oRD_ADDR),
        .oPIX_DATA     (oPIX_DATA),
        .oPIX_VALID    (oPIX_VALID),
        .iPIX_READY    (iPIX_READY),
        .oBUSY         (oBUSY),
        .oDONE         (oDONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    function automatic logic [15:0] data_of(input logic [24:0] a);
        return a[15:0] ^ {a[24:19], 10'h2A5};
    endfunction

    function automatic logic [24:0] exp_addr(input logic [5:0] fr, input int i);
        logic [9:0] ln;
        logic [8:0] wd;
        ln = 10'((i / WPL) % LPF);
        wd = 9'(i % WPL);
        return {fr, ln, wd};
    endfunction

    // SDRAM model: requests seen on a falling edge are accepted at the next rising edge and
    // their data is presented two cycles after acceptance. Also logs accepts and pixel pops.
    always @(negedge iCLK) begin
        if (!iRST_N) begin
            p0_v          <= 1'b0;
            p1_v          <= 1'b0;
            iRD_DATAVALID <= 1'b0;
            iRD_DATA      <= 16'h0;
        end else begin
            iRD_DATAVALID <= p1_v | stray_req;
            iRD_DATA      <= stray_req ? 16'hDEAD : p1_d;
            p1_v          <= p0_v;
            p1_d          <= p0_d;
            p0_v          <= oRD_EN && !iWAIT_REQUEST;
            p0_d          <= data_of(oRD_ADDR);
            if (oRD_EN && !iWAIT_REQUEST) acc_q.push_back(oRD_ADDR);
            if (oPIX_VALID && iPIX_READY) out_q.push_back(oPIX_DATA);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic wait_acc(input int n, input string tag);
        int cyc = 0;
        while (acc_q.size() < n && cyc < 300) begin
            step();
            cyc++;
        end
        check(tag, 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!oDONE && cyc < 600) begin
            step();
            cyc++;
        end
        check(tag, 32'(oDONE), 32'd1);
    endtask

    task automatic check_frame(input int base_a, input int base_o, input logic [5:0] fr,
                               input int n, input string tag);
        check({tag, "_acc_count"}, 32'(acc_q.size() - base_a), 32'(n));
        check({tag, "_out_count"}, 32'(out_q.size() - base_o), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base_a + i < acc_q.size())
                check({tag, "_addr"}, 32'(acc_q[base_a + i]), 32'(exp_addr(fr, i)));
            if (base_o + i < out_q.size())
                check({tag, "_data"}, 32'(out_q[base_o + i]), 32'(data_of(exp_addr(fr, i))));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},   32'(oRD_EN),     32'd0);
        check({tag, "_rd_addr"}, 32'(oRD_ADDR),   32'd0);
        check({tag, "_valid"},   32'(oPIX_VALID), 32'd0);
        check({tag, "_data"},    32'(oPIX_DATA),  32'd0);
        check({tag, "_busy"},    32'(oBUSY),      32'd0);
        check({tag, "_done"},    32'(oDONE),      32'd1);
    endtask

    initial begin
        int base_a;
        int base_o;
        logic [24:0] hold_addr;
        int hold_cnt;

        iRST_N        = 1'b1;
        iSTART        = 1'b0;
        iFRAME_ID     = 6'd0;
        iWAIT_REQUEST = 1'b0;
        iPIX_READY    = 1'b1;
        stray_req     = 1'b0;
        #1 iRST_N = 1'b0;
        #1 check_reset_outputs("reset");
        step();
        step();
        iRST_N = 1'b1;
        step();

        // Stray read data while idle must be dropped.
        stray_req = 1'b1;
        step();
        stray_req = 1'b0;
        step();
        step();
        check("idle_stray_valid", 32'(oPIX_VALID), 32'd0);

        // Frame 5, no stalls, consumer always ready.
        base_a = acc_q.size();
        base_o = out_q.size();
        iFRAME_ID = 6'd5;
        iSTART = 1'b1;
        step();
        check("A_busy", 32'(oBUSY), 32'd1);
        check("A_done_low", 32'(oDONE), 32'd0);
        check("A_rd_en", 32'(oRD_EN), 32'd1);
        check("A_first_addr", 32'(oRD_ADDR), 32'h0028_0000);
        iSTART = 1'b0;
        wait_done("A_done_timeout");
        check("A_words_at_done", 32'(out_q.size() - base_o), 32'(NWORDS));
        check("A_busy_end", 32'(oBUSY), 32'd0);
        check("A_last_addr", 32'(acc_q[acc_q.size() - 1]), 32'h0028_020F);
        check_frame(base_a, base_o, 6'd5, NWORDS, "A");
        step();

        // Consumer stalled: credits must cap the reads at the FIFO depth.
        base_a = acc_q.size();
        base_o = out_q.size();
        iPIX_READY = 1'b0;
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        repeat (60) step();
        check("B_acc_capped", 32'(acc_q.size() - base_a), 32'd16);
        check("B_rd_en_low", 32'(oRD_EN), 32'd0);
        check("B_valid", 32'(oPIX_VALID), 32'd1);
        check("B_head", 32'(oPIX_DATA), 32'(data_of(25'h028_0000)));
        iPIX_READY = 1'b1;
        step();
        iPIX_READY = 1'b0;
        repeat (10) step();
        check("B_one_more", 32'(acc_q.size() - base_a), 32'd17);
        check("B_rd_en_low2", 32'(oRD_EN), 32'd0);
        iPIX_READY = 1'b1;
        wait_done("B_done_timeout");
        check_frame(base_a, base_o, 6'd5, NWORDS, "B");
        step();

        // Controller stall mid-frame, plus a start edge and frame change while busy.
        base_a = acc_q.size();
        base_o = out_q.size();
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        wait_acc(base_a + 10, "C_reach_10");
        iWAIT_REQUEST = 1'b1;
        hold_addr = oRD_ADDR;
        hold_cnt  = acc_q.size();
        check("C_stall_en", 32'(oRD_EN), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 2) begin
                iFRAME_ID = 6'd9;
                iSTART = 1'b1;
            end
            if (i == 6) iSTART = 1'b0;
            check("C_stall_addr", 32'(oRD_ADDR), 32'(hold_addr));
            check("C_stall_en_hold", 32'(oRD_EN), 32'd1);
        end
        check("C_no_accept_in_stall", 32'(acc_q.size()), 32'(hold_cnt));
        iWAIT_REQUEST = 1'b0;
        wait_done("C_done_timeout");
        check_frame(base_a, base_o, 6'd5, NWORDS, "C");
        step();

        // Asynchronous reset mid-frame, then a fresh read of frame 0.
        iFRAME_ID = 6'd5;
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        wait_acc(acc_q.size() + 20, "D_reach_20");
        #2 iRST_N = 1'b0;
        #1 check_reset_outputs("D_async");
        step();
        step();
        iRST_N = 1'b1;
        step();
        check("D_done_after_reset", 32'(oDONE), 32'd1);
        base_a = acc_q.size();
        base_o = out_q.size();
        iFRAME_ID = 6'd0;
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        check("D_busy", 32'(oBUSY), 32'd1);
        check("D_first_addr", 32'(oRD_ADDR), 32'd0);
        wait_done("D_done_timeout");
        check_frame(base_a, base_o, 6'd0, NWORDS, "D");
        step();

`ifdef SDRAM_READER_LOOP_EN
        // Continuous refresh: hold start into the second frame, then release.
        base_a = acc_q.size();
        base_o = out_q.size();
        iFRAME_ID = 6'd5;
        iSTART = 1'b1;
        step();
        wait_acc(base_a + NWORDS + 8, "L_reach_second");
        check("L_busy", 32'(oBUSY), 32'd1);
        check("L_second_start", 32'(acc_q[base_a + NWORDS]), 32'h0028_0000);
        iSTART = 1'b0;
        wait_done("L_done_timeout");
        check_frame(base_a, base_o, 6'd5, 2 * NWORDS, "L");
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
